// File: rtl/alu_operand_loader.sv
// alu_operand_loader: debounced two-press operand sequencer and result/flag register for Sumador_6
module alu_operand_loader #(
  parameter int WIDTH      = 6,
  parameter int DEB_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw,
  input  logic             cin_sw,
  input  logic             load_btn,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic             Cin,
  input  logic [WIDTH-1:0] Y_in,
  input  logic             Cout_in,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             overflow,
  output logic             valid,
  output logic [1:0]       state
);
  typedef enum logic [1:0] {S_A = 2'd0, S_B = 2'd1, S_EXEC = 2'd2, S_DONE = 2'd3} state_t;
  localparam int CW = $clog2(DEB_CYCLES + 1);
  logic          s1, s2;
  logic [CW-1:0] cnt;
  logic          load_pulse;
  state_t        cur, nxt;
  // One pulse exactly when the saturating counter crosses into DEB_CYCLES
  assign load_pulse = s2 && (cnt == CW'(DEB_CYCLES - 1));
  assign state = cur;
  // Synchronise the raw button and count consecutive high cycles, saturating
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      cnt <= '0;
    end else begin
      s1  <= load_btn;
      s2  <= s1;
      cnt <= !s2 ? '0 : (cnt < CW'(DEB_CYCLES)) ? cnt + CW'(1) : cnt;
    end
  // State register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cur <= S_A;
    else cur <= nxt;
  // Next state: presses advance A->B->EXEC, EXEC is a fixed single cycle, a press in DONE restarts at B
  always_comb begin
    nxt = cur;
    case (cur)
      S_A:     nxt = load_pulse ? S_B : S_A;
      S_B:     nxt = load_pulse ? S_EXEC : S_B;
      S_EXEC:  nxt = S_DONE;
      default: nxt = load_pulse ? S_B : S_DONE;
    endcase
  end
  // Operand capture and result/flag registration; flags use the registered operands held stable during EXEC
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      A        <= '0;
      B        <= '0;
      Cin      <= 1'b0;
      result   <= '0;
      carry    <= 1'b0;
      zero     <= 1'b0;
      overflow <= 1'b0;
      valid    <= 1'b0;
    end else begin
      if (load_pulse && (cur == S_A || cur == S_DONE)) A <= sw;
      if (load_pulse && cur == S_B) begin
        B   <= sw;
        Cin <= cin_sw;
      end
      if (cur == S_EXEC) begin
        result   <= Y_in;
        carry    <= Cout_in;
        zero     <= (Y_in == '0);
        overflow <= (A[WIDTH-1] == B[WIDTH-1]) && (Y_in[WIDTH-1] != A[WIDTH-1]);
        valid    <= 1'b1;
      end else if (load_pulse && cur == S_DONE) valid <= 1'b0;
    end
endmodule

// File: tb/tb_alu_operand_loader.sv
// tb_alu_operand_loader: scoreboard bench for the operand loader with a behavioural Sumador_6
module tb_alu_operand_loader;
  localparam int W = 6;
  localparam int DEB = 4;
  logic clk = 1'b0, rst_n = 1'b0, cin_sw = 1'b0, load_btn = 1'b0;
  logic [W-1:0] sw = '0;
  logic [W-1:0] A, B, Y_in, result;
  logic Cin, Cout_in, carry, zero, overflow, valid;
  logic [1:0] state;
  logic [W:0] sum;
  typedef struct {logic [W-1:0] r; logic c, z, o;} exp_t;
  exp_t sb[$];
  int n_cmp = 0, n_err = 0;

  alu_operand_loader #(.WIDTH(W), .DEB_CYCLES(DEB)) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .cin_sw(cin_sw), .load_btn(load_btn),
    .A(A), .B(B), .Cin(Cin), .Y_in(Y_in), .Cout_in(Cout_in),
    .result(result), .carry(carry), .zero(zero), .overflow(overflow),
    .valid(valid), .state(state)
  );

  assign sum = {1'b0, A} + {1'b0, B} + {{W{1'b0}}, Cin};
  assign Y_in = sum[W-1:0];
  assign Cout_in = sum[W];

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    load_btn = 1'b0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Press, report edges until the state moves and valid at that edge and the next, then release
  task automatic press(input logic [W-1:0] v, input logic c, output int lat, output logic v0, output logic v1);
    logic [1:0] prev;
    @(negedge clk);
    sw = v;
    cin_sw = c;
    load_btn = 1'b1;
    prev = state;
    lat = 99;
    v0 = 1'bx;
    v1 = 1'bx;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (state !== prev) begin
        lat = i;
        v0 = valid;
        @(posedge clk);
        #1;
        v1 = valid;
        break;
      end
    end
    repeat (6) @(posedge clk);
    @(negedge clk);
    load_btn = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic do_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    int lat;
    logic v0, v1;
    exp_t e, g;
    logic [W:0] s;
    press(a, 1'b0, lat, v0, v1);
    n_cmp++;
    if (A !== a || state !== 2'd1 || lat !== DEB + 2) begin
      n_err++;
      $display("FAIL %s_loadA: A=%0d state=%0d lat=%0d, want A=%0d state=1 lat=%0d", nm, A, state, lat, a, DEB + 2);
    end
    s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    e.r = s[W-1:0];
    e.c = s[W];
    e.z = (s[W-1:0] == '0);
    e.o = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    sb.push_back(e);
    press(b, c, lat, v0, v1);
    n_cmp++;
    if (lat !== DEB + 2 || v0 !== 1'b0 || v1 !== 1'b1) begin
      n_err++;
      $display("FAIL %s_latency: lat=%0d valid@exec=%b valid@next=%b, want lat=%0d 0 1", nm, lat, v0, v1, DEB + 2);
    end
    for (int i = 0; i < 20 && !valid; i++) @(negedge clk);
    g.r = result; g.c = carry; g.z = zero; g.o = overflow;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_scoreboard: empty queue", nm);
    end else begin
      e = sb.pop_front();
      n_cmp++;
      if (g.r !== e.r || g.c !== e.c || g.z !== e.z || g.o !== e.o) begin
        n_err++;
        $display("FAIL %s_result: got r=%0d c=%b z=%b o=%b, want r=%0d c=%b z=%b o=%b", nm, g.r, g.c, g.z, g.o, e.r, e.c, e.z, e.o);
      end
    end
    n_cmp++;
    if (valid !== 1'b1 || state !== 2'd3 || A !== a || B !== b || Cin !== c) begin
      n_err++;
      $display("FAIL %s_done: valid=%b state=%0d A=%0d B=%0d Cin=%b, want 1 3 %0d %0d %b", nm, valid, state, A, B, Cin, a, b, c);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({A, B, Cin, result, carry, zero, overflow, valid, state} !== '0) begin
      n_err++;
      $display("FAIL reset_async: A=%0d B=%0d Cin=%b res=%0d c=%b z=%b o=%b v=%b st=%0d, want all 0", A, B, Cin, result, carry, zero, overflow, valid, state);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    n_cmp++;
    if (state !== 2'd0 || valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle: state=%0d valid=%b, want 0 0", state, valid);
    end
  endtask

  task automatic test_ops();
    do_op("add54_12", 6'b110110, 6'd12, 1'b0);
    do_op("ovf31_1", 6'd31, 6'd1, 1'b0);
    do_op("zero63_0", 6'd63, 6'd0, 1'b1);
  endtask

  task automatic test_done_reload();
    int lat;
    logic v0, v1;
    press(6'd5, 1'b0, lat, v0, v1);
    n_cmp++;
    if (A !== 6'd5 || valid !== 1'b0 || result !== 6'd0 || zero !== 1'b1 || carry !== 1'b1 || state !== 2'd1) begin
      n_err++;
      $display("FAIL done_reload: A=%0d v=%b res=%0d z=%b c=%b st=%0d, want 5 0 0 1 1 1", A, valid, result, zero, carry, state);
    end
  endtask

  task automatic test_bounce();
    int moves = 0, pre = 0;
    logic [1:0] prev;
    logic [8:0] pat = 9'b110110110;
    do_reset();
    sw = 6'd9;
    prev = state;
    for (int i = 8; i >= 0; i--) begin
      @(negedge clk);
      load_btn = pat[i];
      @(posedge clk);
      #1;
      if (state !== prev) begin moves++; prev = state; end
    end
    pre = moves;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      load_btn = 1'b1;
      @(posedge clk);
      #1;
      if (state !== prev) begin moves++; prev = state; end
    end
    @(negedge clk);
    load_btn = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (state !== prev) begin moves++; prev = state; end
    end
    n_cmp++;
    if (pre !== 0) begin
      n_err++;
      $display("FAIL bounce_glitch: advances during glitches=%0d, want 0", pre);
    end
    n_cmp++;
    if (moves !== 1 || state !== 2'd1 || A !== 6'd9) begin
      n_err++;
      $display("FAIL bounce_single: advances=%0d state=%0d A=%0d, want 1 1 9", moves, state, A);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic v0, v1;
    do_reset();
    press(6'd54, 1'b0, lat, v0, v1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (A !== 6'd0 || state !== 2'd0) begin
      n_err++;
      $display("FAIL reset_mid: A=%0d state=%0d, want 0 0", A, state);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_op("after_rst", 6'd20, 6'd43, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++)
      do_op("rand", 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
  endtask

  initial begin
    test_reset();
    test_ops();
    test_done_reload();
    test_bounce();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/alu_operand_loader.md
Name: alu_operand_loader

Overview:
Upstream operand sequencer and downstream result register for the 6-bit adder `Sumador_6`. Captures A, then B and Cin, from the board switches on successive debounced presses of a load button. It drives these operands into `Sumador_6`, waits one cycle, then registers Y/Cout together with zero and overflow flags. It sits between the board I/O (switches, button) and the display/flag logic of the ALU.

Parameters:
WIDTH, 6, operand/result width; must match `Sumador_6`.
DEB_CYCLES, 16, consecutive synchronised-high cycles required to accept a button press (TB uses 4).

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
sw  input  WIDTH  operand switches
cin_sw  input  1  carry-in switch
load_btn  input  1  raw, asynchronous, bouncing load button
A  output  WIDTH  operand A to `Sumador_6`
B  output  WIDTH  operand B to `Sumador_6`
Cin  output  1  carry-in to `Sumador_6`
Y_in  input  WIDTH  sum from `Sumador_6` (combinational)
Cout_in  input  1  carry-out from `Sumador_6`
result  output  WIDTH  registered sum
carry  output  1  registered Cout
zero  output  1  1 when registered sum == 0
overflow  output  1  signed two's-complement overflow
valid  output  1  result/flags hold a completed operation
state  output  2  current FSM state (debug/LED)

Behaviour:
- Reset (rst_n=0, asynchronous): A, B, Cin, result, carry, zero, overflow and valid are 0. state=S_A. Sync flops and debounce counter are 0. Reset mid-operation aborts unconditionally; no partial operand survives.
- Button conditioning:
  - load_btn passes through a 2-FF synchroniser; the output is s.
  - Counter cnt: cleared whenever s=0; increments while s=1 and cnt<DEB_CYCLES; saturates at DEB_CYCLES.
  - load_pulse is high for exactly one cycle, on the cycle cnt goes from DEB_CYCLES-1 to DEB_CYCLES.
  - A held button produces a single pulse; re-arming requires s=0 for at least one cycle.
  - A clean press asserted before clock edge t0 gives load_pulse during cycle t0+1+DEB_CYCLES. The action takes effect at the next edge.
  - Any high glitch shorter than DEB_CYCLES synchronised cycles produces no pulse.
- FSM states (encoding): S_A=0, S_B=1, S_EXEC=2, S_DONE=3.
  - S_A: on load_pulse, A<=sw, go to S_B. Otherwise hold.
  - S_B: on load_pulse, B<=sw, Cin<=cin_sw, go to S_EXEC.
  - S_EXEC: unconditional single cycle. Capture the adder output (operands are now stable for one full cycle):
    - result<=Y_in, carry<=Cout_in
    - zero<=(Y_in==0)
    - overflow<=(A[W-1]==B[W-1]) && (Y_in[W-1]!=A[W-1])
    - valid<=1; go to S_DONE.
  - S_DONE: hold result, flags and valid. On load_pulse: A<=sw, valid<=0, result and flags unchanged, go to S_B.
- load_pulse arriving in S_EXEC is ignored (it is not queued).
- A, B and Cin change only on the edges listed above; they are glitch-free registered outputs.
- Latency: from the load_pulse that captures B, result and valid update at the 2nd following clock edge.
- Arithmetic is modulo 2^WIDTH. Carry and overflow are independent flags.

Test Plan:
1. rst_n=0 asserted asynchronously mid-cycle → all outputs 0 immediately, state=0. Release rst_n, no presses for 100 cycles → state stays 0, valid=0.
2. DEB_CYCLES=4. sw=6'b110110, press; sw=6'd12, cin_sw=0, press → A=54, B=12. Two cycles after the second pulse: result=6'd2, carry=1, zero=0, overflow=0, valid=1, state=3.
3. A=31, B=1, Cin=0 → result=6'b100000, carry=0, overflow=1, zero=0.
4. A=63, B=0, Cin=1 → result=0, carry=1, zero=1, overflow=0. Then a press with sw=5 in S_DONE → A=5, valid=0, result still 0, state=1.
5. Bounce test: load_btn toggles high for 2 cycles ×3 with 1-cycle lows, then stays high 20 cycles → exactly one load_pulse, exactly one state advance.
6. Assert rst_n=0 while in S_B with A=54 latched → A=0, state=0. A new sequence completes correctly.
